fft_bitrev_reorder: RTL and testbench

Output reorder buffer for the 256-point radix-2 FFT. It sits after the last butterfly stage. It accepts the FFT's bit-reversed-order output stream (valid-only, no backpressure) and writes each sample to its bit-reversed address in a ping-pong RAM. It then reads the samples back in natural order to a downstream consumer over a valid/ready handshake, so one frame can be written while the previous one is drained.

---
 rtl/fft_bitrev_reorder.sv | 143 ++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong bit-reversed to natural-order reorder buffer; optional frame drop via FFT_REORDER_OVF_EN
module fft_bitrev_reorder #(
  parameter int N     = 256,
  parameter int LOG2N = 8,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [DW-1:0]    in_re,
  input  logic [DW-1:0]    in_im,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic [LOG2N-1:0] out_idx,
  output logic             out_last,
  output logic [1:0]       bank_full,
  output logic             ovf
);
  typedef enum logic {W_FILL, W_DROP} w_state_t;
  typedef enum logic {R_IDLE, R_READ} r_state_t;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
  w_state_t ws, ws_n;
  r_state_t rs, rs_n;
  logic [LOG2N-1:0] wcnt, waddr, rcnt, sk_idx;
  logic wb, rb, nrb, rdone, rdone_n, we, xfer, last_x, start, issue, sv;
  logic [1:0] bank_full_n;
  logic [2*DW-1:0] mem [2*N];
  logic [2*DW-1:0] rdata, sk_d;
  for (genvar i = 0; i < LOG2N; i++) begin : g_br
    assign waddr[i] = wcnt[LOG2N-1-i];
  end
  assign rdata    = mem[{nrb, rcnt}];
  assign out_last = out_vld && out_idx == LAST;
`ifdef FFT_REORDER_OVF_EN
  logic [LOG2N-1:0] dcnt, dcnt_n;
  // write-side next state: drop a whole frame when the target bank is still full
  always_comb begin
    ws_n   = ws;
    we     = 1'b0;
    dcnt_n = dcnt;
    if (in_vld && ws == W_DROP) begin
      dcnt_n = dcnt + 1'b1;
      ws_n   = dcnt == LAST ? W_FILL : W_DROP;
    end else if (in_vld && wcnt == '0 && bank_full[wb]) begin
      ws_n   = W_DROP;
      dcnt_n = LOG2N'(1);
    end else begin
      we = in_vld;
    end
  end
  // drop counter and sticky overflow flag
  always_ff @(posedge clk) begin
    dcnt <= rst ? '0 : dcnt_n;
    ovf  <= rst ? 1'b0 : ovf | (ws_n == W_DROP);
  end
`else
  // write-side next state: every valid sample is written, full or not
  always_comb begin
    ws_n = ws;
    we   = in_vld && ws == W_FILL;
  end
  assign ovf = 1'b0;
`endif
  // write state, pointer and bank select
  always_ff @(posedge clk) begin
    if (rst) begin
      ws   <= W_FILL;
      wcnt <= '0;
      wb   <= 1'b0;
    end else begin
      ws <= ws_n;
      if (we) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == LAST) wb <= ~wb;
      end
    end
  end
  // sample storage, written at the bit-reversed address
  always_ff @(posedge clk) begin
    if (we) mem[{wb, waddr}] <= {in_re, in_im};
  end
  // read-side next state; the next bank starts in the same cycle the last bin leaves
  always_comb begin
    xfer        = out_vld && out_rdy;
    last_x      = xfer && out_last;
    nrb         = rb ^ last_x;
    start       = (rs == R_IDLE || last_x) && bank_full[nrb];
    issue       = (start || (rs == R_READ && !rdone)) && (!sv || xfer);
    rs_n        = start ? R_READ : last_x ? R_IDLE : rs;
    rdone_n     = (issue && rcnt == LAST) ? 1'b1 : (start || last_x) ? 1'b0 : rdone;
    bank_full_n = bank_full;
    if (we && wcnt == LAST) bank_full_n[wb] = 1'b1;
    if (last_x) bank_full_n[rb] = 1'b0;
  end
  // read state, pointer, bank select and full flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rs        <= R_IDLE;
      rb        <= 1'b0;
      rcnt      <= '0;
      rdone     <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      rs        <= rs_n;
      rb        <= nrb;
      rcnt      <= rcnt + LOG2N'(issue);
      rdone     <= rdone_n;
      bank_full <= bank_full_n;
    end
  end
  // output register with skid: reads land in the output reg if it frees up, else in the skid
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_re  <= '0;
      out_im  <= '0;
      out_idx <= '0;
      sv      <= 1'b0;
      sk_d    <= '0;
      sk_idx  <= '0;
    end else if (!out_vld || xfer) begin
      out_vld <= sv || issue;
      if (sv) begin
        {out_re, out_im} <= sk_d;
        out_idx          <= sk_idx;
        sv               <= issue;
      end else if (issue) begin
        {out_re, out_im} <= rdata;
        out_idx          <= rcnt;
      end
      if (sv && issue) begin
        sk_d   <= rdata;
        sk_idx <= rcnt;
      end
    end else if (issue) begin
      sk_d   <= rdata;
      sk_idx <= rcnt;
      sv     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: directed checks of reorder, handshake, back-to-back frames, reset and optional drop
module tb_fft_bitrev_reorder;
  localparam int N = 256, LOG2N = 8, DW = 16;
  logic clk = 1'b0, rst = 1'b1, in_vld = 1'b0, out_rdy = 1'b0;
  logic [DW-1:0] in_re = '0, in_im = '0, out_re, out_im;
  logic [LOG2N-1:0] out_idx;
  logic out_vld, out_last, ovf;
  logic [1:0] bank_full;
  int n_chk = 0, n_pass = 0;
  logic signed [DW-1:0] q_re[$], q_im[$];
  logic [LOG2N-1:0] q_idx[$];
  logic q_last[$];
  int q_cyc[$];
  int cyc = 0, stab_err = 0, bf11 = 0;
  logic stall_prev = 1'b0, p_last;
  logic [DW-1:0] p_re, p_im;
  logic [LOG2N-1:0] p_idx;
  fft_bitrev_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_re(in_re), .in_im(in_im),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .bank_full(bank_full), .ovf(ovf)
  );
  always #5 clk = ~clk;
  // collect transfers, flag unstable stalled outputs and both-banks-full cycles
  always @(negedge clk) begin
    cyc++;
    if (rst) stall_prev = 1'b0;
    else begin
      if (stall_prev && (!out_vld || out_re !== p_re || out_im !== p_im || out_idx !== p_idx || out_last !== p_last)) stab_err++;
      if (out_vld && out_rdy) begin
        q_re.push_back(out_re);
        q_im.push_back(out_im);
        q_idx.push_back(out_idx);
        q_last.push_back(out_last);
        q_cyc.push_back(cyc);
      end
      if (bank_full == 2'b11) bf11++;
      stall_prev = out_vld && !out_rdy;
      p_re = out_re;
      p_im = out_im;
      p_idx = out_idx;
      p_last = out_last;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int br(input int k);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) r |= ((k >> i) & 1) << (LOG2N - 1 - i);
    return r;
  endfunction
  task automatic clear();
    q_re.delete();
    q_im.delete();
    q_idx.delete();
    q_last.delete();
    q_cyc.delete();
    stab_err = 0;
    bf11 = 0;
  endtask
  task automatic send_frame(input int f, input int gap);
    for (int k = 0; k < N; k++) begin
      in_vld = 1'b1;
      in_re = 16'(f * 256 + k);
      in_im = 16'(-(f * 256 + k));
      step();
      in_vld = 1'b0;
      repeat (gap) step();
    end
    in_vld = 1'b0;
  endtask
  task automatic drain(input int target, input bit rnd);
    for (int c = 0; c < 4000 && q_re.size() < target; c++) begin
      out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    out_rdy = 1'b1;
  endtask
  task automatic verify(input string tag, input int nfr, input int f0);
    int e_d = 0, e_i = 0, e_l = 0, v;
    check({tag, "_count"}, q_re.size(), nfr * N);
    for (int i = 0; i < q_re.size(); i++) begin
      v = (f0 + i / N) * 256 + br(i % N);
      if (q_re[i] !== 16'(v) || q_im[i] !== 16'(-v)) e_d++;
      if (q_idx[i] !== 8'(i % N)) e_i++;
      if (q_last[i] !== (i % N == N - 1)) e_l++;
    end
    check({tag, "_data_errs"}, e_d, 0);
    check({tag, "_idx_errs"}, e_i, 0);
    check({tag, "_last_errs"}, e_l, 0);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_vld"}, out_vld, 0);
    check({tag, "_re"}, out_re, 0);
    check({tag, "_im"}, out_im, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_bank_full"}, bank_full, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask
  initial begin
    int g;
    repeat (3) step();
    check_reset("init");
    rst = 1'b0;
    // single contiguous frame, latency and spot bins
    clear();
    out_rdy = 1'b1;
    send_frame(0, 0);
    check("lat_bank_full_t1", bank_full, 2'b01);
    check("lat_vld_t1", out_vld, 0);
    step();
    check("lat_vld_t2", out_vld, 1);
    check("lat_idx_t2", out_idx, 0);
    drain(N, 0);
    verify("single", 1, 0);
    check("bin1_re", $signed(q_re[1]), 128);
    check("bin1_im", $signed(q_im[1]), -128);
    check("bin2_re", $signed(q_re[2]), 64);
    check("bin255_re", $signed(q_re[255]), 255);
    check("bin255_last", q_last[255], 1);
    check("single_bank_full_after", bank_full, 0);
    // two frames back to back, sustained drain
    clear();
    send_frame(1, 0);
    send_frame(2, 0);
    drain(2 * N, 0);
    verify("b2b", 2, 1);
    g = 0;
    for (int i = 1; i < q_cyc.size(); i++) if (q_cyc[i] - q_cyc[i-1] != 1) g++;
    check("b2b_gaps", g, 0);
    check("b2b_bf11_at_most_1", bf11 <= 1, 1);
    // random downstream ready
    clear();
    out_rdy = 1'b0;
    send_frame(3, 0);
    drain(N, 1);
    verify("rand", 1, 3);
    check("rand_stall_unstable", stab_err, 0);
    // input valid one cycle in three
    clear();
    out_rdy = 1'b1;
    send_frame(0, 2);
    drain(N, 0);
    verify("gapped", 1, 0);
`ifdef FFT_REORDER_OVF_EN
    // third frame into two full banks is dropped
    clear();
    out_rdy = 1'b0;
    send_frame(4, 0);
    send_frame(5, 0);
    send_frame(6, 0);
    check("ovf_set", ovf, 1);
    check("ovf_bank_full", bank_full, 2'b11);
    drain(2 * N, 0);
    verify("ovf", 2, 4);
    check("ovf_bank_full_after", bank_full, 0);
    clear();
    send_frame(7, 0);
    drain(N, 0);
    verify("post_drop", 1, 7);
`else
    check("ovf_off", ovf, 0);
`endif
    // reset while a frame is stalled at the output and another is half written
    clear();
    out_rdy = 1'b0;
    send_frame(8, 0);
    repeat (2) step();
    check("pre_rst_vld", out_vld, 1);
    for (int k = 0; k < 100; k++) begin
      in_vld = 1'b1;
      in_re = 16'(k);
      in_im = 16'(k);
      step();
    end
    in_vld = 1'b0;
    rst = 1'b1;
    step();
    check_reset("mid_rst");
    rst = 1'b0;
    clear();
    out_rdy = 1'b1;
    send_frame(9, 0);
    drain(N, 0);
    verify("post_rst", 1, 9);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
